// File: rtl/ub_pkg.sv
// Shared types and constants for the unified-buffer sequencer.
package ub_pkg;

    localparam int ADDR_W    = 13;
    localparam int DATA_W    = 8;
    localparam int MEM_W     = 16;
    localparam int ARRAY_DIM = 2;
    localparam int BURST_LEN = ARRAY_DIM * ARRAY_DIM;
    localparam int CNT_W     = $clog2(BURST_LEN) + 1;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RD_WEIGHT = 3'd1,
        RD_INPUT  = 3'd2,
        WR_STORE  = 3'd3,
        DRAIN     = 3'd4
    } ub_state_t;

    typedef enum logic [2:0] {
        LOAD_ADDR   = 3'b001,
        LOAD_WEIGHT = 3'b010,
        LOAD_INPUTS = 3'b011,
        VALID       = 3'b100,
        STORE       = 3'b101
    } ub_opcode_t;

    // True when a burst starting at base would run past the top of the buffer.
    function automatic logic burst_overflows(input logic [ADDR_W-1:0] base);
        logic [ADDR_W:0] last;
        last = {1'b0, base} + (ADDR_W+1)'(BURST_LEN - 1);
        return last[ADDR_W];
    endfunction

endpackage

// File: rtl/ub_addr_gen.sv
// Burst address generator: latches the base, counts words, wraps modulo 2^ADDR_W.
module ub_addr_gen
    import ub_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_load,
    input  logic              i_step,
    input  logic [ADDR_W-1:0] i_base,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_last
);

    logic [ADDR_W-1:0] r_base;
    logic [CNT_W-1:0]  r_cnt;

    // A load may issue word 0 in the same cycle, so the counter then starts at 1.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_base <= '0;
            r_cnt  <= '0;
        end else if (i_load) begin
            r_base <= i_base;
            r_cnt  <= i_step ? CNT_W'(1) : '0;
        end else if (i_step) begin
            r_cnt  <= r_cnt + CNT_W'(1);
        end
    end

    assign o_addr = i_load ? i_base : (r_base + ADDR_W'(r_cnt));
    assign o_last = !i_load && (r_cnt == CNT_W'(BURST_LEN - 1));

endmodule

// File: rtl/ub_sequencer.sv
// Unified-buffer burst sequencer between the instruction control unit and the SRAM.
// Optional UB_BOUNDS_CHECK_EN adds the sticky bound_err output and rejects overflowing bursts.
module ub_sequencer
    import ub_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load_weight,
    input  logic              load_input,
    input  logic              store,
    input  logic [ADDR_W-1:0] base_address,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [MEM_W-1:0]  mem_rdata,
    output logic              mem_wr_en,
    output logic [MEM_W-1:0]  mem_wdata,
    output logic [DATA_W-1:0] weight_data,
    output logic              weight_valid,
    output logic [DATA_W-1:0] input_data,
    output logic              input_valid,
    input  logic [MEM_W-1:0]  result_data,
    input  logic              result_valid,
    output logic              result_ready,
    output logic              busy,
`ifdef UB_BOUNDS_CHECK_EN
    output logic              bound_err,
`endif
    output logic              done
);

    ub_state_t         r_state, w_next_state;
    logic [ADDR_W-1:0] r_mem_addr, w_addr_out, w_addr;
    logic [MEM_W-1:0]  r_mem_wdata, w_wdata;
    logic              r_mem_rd_en, r_mem_wr_en, w_rd_en, w_wr_en;
    logic              r_weight_valid, r_input_valid, r_target_weight;
    logic              r_result_ready, r_busy, r_done;
    logic              w_ready, w_busy, w_done;
    logic              w_load, w_step, w_last, w_cmd, w_reject;
    logic              w_rdata_unused;

    assign w_cmd          = store | load_weight | load_input;
    assign w_rdata_unused = ^mem_rdata[MEM_W-1:DATA_W];

`ifdef UB_BOUNDS_CHECK_EN
    logic r_bound_err;
    assign w_reject  = burst_overflows(base_address);
    assign bound_err = r_bound_err;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_bound_err <= 1'b0;
        else if ((r_state == IDLE) && w_cmd && w_reject)
            r_bound_err <= 1'b1;
    end
`else
    assign w_reject = 1'b0;
`endif

    ub_addr_gen u_addr_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .i_load  (w_load),
        .i_step  (w_step),
        .i_base  (base_address),
        .o_addr  (w_addr),
        .o_last  (w_last)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_state <= IDLE;
        else
            r_state <= w_next_state;
    end

    // Everything below computes the values the output registers take at the next edge.
    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_step       = 1'b0;
        w_rd_en      = 1'b0;
        w_wr_en      = 1'b0;
        w_addr_out   = '0;
        w_wdata      = '0;
        w_ready      = 1'b0;
        w_busy       = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_cmd && w_reject) begin
                    w_done = 1'b1;
                end else if (w_cmd) begin
                    w_load = 1'b1;
                    w_busy = 1'b1;
                    if (store) begin
                        w_next_state = WR_STORE;
                        w_ready      = 1'b1;
                    end else begin
                        w_next_state = load_weight ? RD_WEIGHT : RD_INPUT;
                        w_step       = 1'b1;
                        w_rd_en      = 1'b1;
                        w_addr_out   = w_addr;
                    end
                end
            end
            RD_WEIGHT, RD_INPUT: begin
                w_busy     = 1'b1;
                w_step     = 1'b1;
                w_rd_en    = 1'b1;
                w_addr_out = w_addr;
                if (w_last)
                    w_next_state = DRAIN;
            end
            DRAIN: begin
                w_done       = 1'b1;
                w_next_state = IDLE;
            end
            WR_STORE: begin
                w_busy  = 1'b1;
                w_ready = 1'b1;
                if (result_valid && r_result_ready) begin
                    w_step     = 1'b1;
                    w_wr_en    = 1'b1;
                    w_addr_out = w_addr;
                    w_wdata    = result_data;
                    if (w_last) begin
                        w_next_state = IDLE;
                        w_busy       = 1'b0;
                        w_ready      = 1'b0;
                        w_done       = 1'b1;
                    end
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mem_addr      <= '0;
            r_mem_rd_en     <= 1'b0;
            r_mem_wr_en     <= 1'b0;
            r_mem_wdata     <= '0;
            r_weight_valid  <= 1'b0;
            r_input_valid   <= 1'b0;
            r_target_weight <= 1'b0;
            r_result_ready  <= 1'b0;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
        end else begin
            r_mem_addr     <= w_addr_out;
            r_mem_rd_en    <= w_rd_en;
            r_mem_wr_en    <= w_wr_en;
            r_mem_wdata    <= w_wdata;
            r_weight_valid <= r_mem_rd_en & r_target_weight;
            r_input_valid  <= r_mem_rd_en & ~r_target_weight;
            r_result_ready <= w_ready;
            r_busy         <= w_busy;
            r_done         <= w_done;
            if (w_load)
                r_target_weight <= load_weight & ~store;
        end
    end

    // SRAM read data is already registered; the valid flags line up with it and gate it.
    assign weight_data  = r_weight_valid ? mem_rdata[DATA_W-1:0] : '0;
    assign input_data   = r_input_valid  ? mem_rdata[DATA_W-1:0] : '0;
    assign mem_addr     = r_mem_addr;
    assign mem_rd_en    = r_mem_rd_en;
    assign mem_wr_en    = r_mem_wr_en;
    assign mem_wdata    = r_mem_wdata;
    assign weight_valid = r_weight_valid;
    assign input_valid  = r_input_valid;
    assign result_ready = r_result_ready;
    assign busy         = r_busy;
    assign done         = r_done;

endmodule

// File: tb/tb_ub_sequencer.sv
// Scoreboard bench for ub_sequencer: stimulus pushes expected events, a negedge monitor pops them.
module tb_ub_sequencer;

    localparam logic [31:0] NONE = 32'hDEAD_BEEF;

    logic        clk;
    logic        reset_n;
    logic        load_weight, load_input, store;
    logic [12:0] base_address;
    logic [12:0] mem_addr;
    logic        mem_rd_en, mem_wr_en;
    logic [15:0] mem_rdata, mem_wdata;
    logic [7:0]  weight_data, input_data;
    logic        weight_valid, input_valid;
    logic [15:0] result_data;
    logic        result_valid, result_ready;
    logic        busy, done;
`ifdef UB_BOUNDS_CHECK_EN
    logic        bound_err;
`endif

    logic [15:0] mem [0:8191];
    logic [31:0] rdQ[$], wrQ[$], wQ[$], iQ[$], doneQ[$];
    int          errors;
    int          checks;

    ub_sequencer dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .load_weight  (load_weight),
        .load_input   (load_input),
        .store        (store),
        .base_address (base_address),
        .mem_addr     (mem_addr),
        .mem_rd_en    (mem_rd_en),
        .mem_rdata    (mem_rdata),
        .mem_wr_en    (mem_wr_en),
        .mem_wdata    (mem_wdata),
        .weight_data  (weight_data),
        .weight_valid (weight_valid),
        .input_data   (input_data),
        .input_valid  (input_valid),
        .result_data  (result_data),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .busy         (busy),
`ifdef UB_BOUNDS_CHECK_EN
        .bound_err    (bound_err),
`endif
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous single-port SRAM: read data appears the cycle after the strobe.
    initial mem_rdata = '0;
    always @(posedge clk) begin
        if (mem_rd_en)
            mem_rdata <= mem[mem_addr];
        if (mem_wr_en)
            mem[mem_addr] <= mem_wdata;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, expv);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic lw, input logic li, input logic st, input logic [12:0] base);
        load_weight  = lw;
        load_input   = li;
        store        = st;
        base_address = base;
        tick();
        load_weight  = 1'b0;
        load_input   = 1'b0;
        store        = 1'b0;
    endtask

    task automatic waitDrain(input int budget);
        bit empty;
        empty = 1'b0;
        for (int i = 0; i < budget && !empty; i++) begin
            tick();
            empty = (rdQ.size() == 0) && (wrQ.size() == 0) && (wQ.size() == 0) &&
                    (iQ.size() == 0) && (doneQ.size() == 0);
        end
        if (!empty)
            checkOutput("drain_timeout", 32'(rdQ.size() + wrQ.size() + wQ.size() + iQ.size() + doneQ.size()), 0);
    endtask

    always @(negedge clk) begin : monitor
        logic [31:0] expv;
        if (mem_rd_en && mem_wr_en)
            checkOutput("rd_wr_mutex", 32'(mem_rd_en & mem_wr_en), 0);
        if (mem_rd_en) begin
            if (rdQ.size() != 0) expv = rdQ.pop_front(); else expv = NONE;
            checkOutput("rd_addr", 32'(mem_addr), expv);
        end
        if (mem_wr_en) begin
            if (wrQ.size() != 0) expv = wrQ.pop_front(); else expv = NONE;
            checkOutput("wr_addr_data", {3'b0, mem_addr, mem_wdata}, expv);
        end
        if (weight_valid) begin
            if (wQ.size() != 0) expv = wQ.pop_front(); else expv = NONE;
            checkOutput("weight_data", 32'(weight_data), expv);
        end
        if (input_valid) begin
            if (iQ.size() != 0) expv = iQ.pop_front(); else expv = NONE;
            checkOutput("input_data", 32'(input_data), expv);
        end
        if (done) begin
            if (doneQ.size() != 0) expv = doneQ.pop_front(); else expv = NONE;
            checkOutput("done_pulse", 32'(done), expv);
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [15:0] pat_d [6];
        logic        pat_v [6];
        bit          found;
        errors = 0;
        checks = 0;
        for (int i = 0; i < 8192; i++) mem[i] = '0;
        for (int i = 0; i < 4; i++) begin
            mem[13'h010 + i] = {8'hA0 + 8'(i), 8'd5 + 8'(i)};
            mem[13'h020 + i] = {8'h5A, 8'h30 + 8'(i)};
            mem[13'h040 + i] = 16'h0050 + 16'(i);
            mem[13'h060 + i] = 16'h0070 + 16'(i);
        end
        reset_n = 1'b0;
        load_weight = 1'b0; load_input = 1'b0; store = 1'b0;
        base_address = '0; result_data = '0; result_valid = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
        tick();
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_rd_en", 32'(mem_rd_en), 0);
        checkOutput("rst_wr_en", 32'(mem_wr_en), 0);
        checkOutput("rst_ready", 32'(result_ready), 0);
`ifdef UB_BOUNDS_CHECK_EN
        checkOutput("rst_bound_err", 32'(bound_err), 0);
`endif

        $display("[TB] load_weight burst at 0x010");
        rdQ.push_back(32'h010); rdQ.push_back(32'h011); rdQ.push_back(32'h012); rdQ.push_back(32'h013);
        wQ.push_back(32'd5); wQ.push_back(32'd6); wQ.push_back(32'd7); wQ.push_back(32'd8);
        doneQ.push_back(32'd1);
        applyStimulus(1'b1, 1'b0, 1'b0, 13'h010);
        checkOutput("lw_busy", 32'(busy), 1);
        waitDrain(20);
        checkOutput("lw_idle_busy", 32'(busy), 0);

`ifndef UB_BOUNDS_CHECK_EN
        $display("[TB] store wrapping at 0x1FFE with stalls");
        wrQ.push_back(32'h1FFE_A001); wrQ.push_back(32'h1FFF_A002);
        wrQ.push_back(32'h0000_A003); wrQ.push_back(32'h0001_A004);
        doneQ.push_back(32'd1);
        pat_v = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        pat_d = '{16'hA001, 16'hDEAD, 16'hA002, 16'hA003, 16'hBEEF, 16'hA004};
        applyStimulus(1'b0, 1'b0, 1'b1, 13'h1FFE);
        checkOutput("st_ready", 32'(result_ready), 1);
        checkOutput("st_busy", 32'(busy), 1);
        for (int i = 0; i < 6; i++) begin
            result_valid = pat_v[i];
            result_data  = pat_d[i];
            tick();
        end
        result_valid = 1'b0;
        checkOutput("st_ready_after_last", 32'(result_ready), 0);
        checkOutput("st_busy_after_last", 32'(busy), 0);
        waitDrain(10);
`endif

        $display("[TB] load_weight and store together");
        wrQ.push_back(32'h0100_B001); wrQ.push_back(32'h0101_B002);
        wrQ.push_back(32'h0102_B003); wrQ.push_back(32'h0103_B004);
        doneQ.push_back(32'd1);
        applyStimulus(1'b1, 1'b0, 1'b1, 13'h0100);
        checkOutput("prio_ready", 32'(result_ready), 1);
        for (int i = 0; i < 4; i++) begin
            result_valid = 1'b1;
            result_data  = 16'hB001 + 16'(i);
            tick();
        end
        result_valid = 1'b0;
        waitDrain(10);

        $display("[TB] busy-ignored and back-to-back commands");
        rdQ.push_back(32'h020); rdQ.push_back(32'h021); rdQ.push_back(32'h022); rdQ.push_back(32'h023);
        wQ.push_back(32'h30); wQ.push_back(32'h31); wQ.push_back(32'h32); wQ.push_back(32'h33);
        doneQ.push_back(32'd1);
        applyStimulus(1'b1, 1'b0, 1'b0, 13'h020);
        tick();
        checkOutput("ign_busy", 32'(busy), 1);
        applyStimulus(1'b0, 1'b1, 1'b0, 13'h055);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (done) found = 1'b1;
            else tick();
        end
        if (!found) checkOutput("b2b_done_timeout", 32'(done), 1);
        rdQ.push_back(32'h040); rdQ.push_back(32'h041); rdQ.push_back(32'h042); rdQ.push_back(32'h043);
        iQ.push_back(32'h50); iQ.push_back(32'h51); iQ.push_back(32'h52); iQ.push_back(32'h53);
        doneQ.push_back(32'd1);
        applyStimulus(1'b0, 1'b1, 1'b0, 13'h040);
        checkOutput("b2b_rd_en", 32'(mem_rd_en), 1);
        checkOutput("b2b_addr", 32'(mem_addr), 32'h040);
        waitDrain(20);

        $display("[TB] reset in the middle of a weight burst");
        rdQ.push_back(32'h060); rdQ.push_back(32'h061); rdQ.push_back(32'h062);
        wQ.push_back(32'h70); wQ.push_back(32'h71);
        applyStimulus(1'b1, 1'b0, 1'b0, 13'h060);
        tick();
        tick();
        #1;
        reset_n = 1'b0;
        #1;
        checkOutput("mid_rst_addr", 32'(mem_addr), 0);
        checkOutput("mid_rst_rd_en", 32'(mem_rd_en), 0);
        checkOutput("mid_rst_wr_en", 32'(mem_wr_en), 0);
        checkOutput("mid_rst_wdata", 32'(mem_wdata), 0);
        checkOutput("mid_rst_wvalid", 32'(weight_valid), 0);
        checkOutput("mid_rst_wdata_arr", 32'(weight_data), 0);
        checkOutput("mid_rst_ivalid", 32'(input_valid), 0);
        checkOutput("mid_rst_idata", 32'(input_data), 0);
        checkOutput("mid_rst_ready", 32'(result_ready), 0);
        checkOutput("mid_rst_busy", 32'(busy), 0);
        checkOutput("mid_rst_done", 32'(done), 0);
        tick();
        reset_n = 1'b1;
        repeat (3) tick();
        checkOutput("post_rst_busy", 32'(busy), 0);
        checkOutput("post_rst_rd_en", 32'(mem_rd_en), 0);
        checkOutput("post_rst_wr_en", 32'(mem_wr_en), 0);

`ifdef UB_BOUNDS_CHECK_EN
        $display("[TB] out-of-range load_input at 0x1FFE");
        doneQ.push_back(32'd1);
        applyStimulus(1'b0, 1'b1, 1'b0, 13'h1FFE);
        checkOutput("bound_err_set", 32'(bound_err), 1);
        checkOutput("bound_busy", 32'(busy), 0);
        checkOutput("bound_rd_en", 32'(mem_rd_en), 0);
        repeat (3) tick();
        checkOutput("bound_err_sticky", 32'(bound_err), 1);
        waitDrain(5);
`endif

        checkOutput("end_rdq", 32'(rdQ.size()), 0);
        checkOutput("end_wrq", 32'(wrQ.size()), 0);
        checkOutput("end_wq", 32'(wQ.size()), 0);
        checkOutput("end_iq", 32'(iQ.size()), 0);
        checkOutput("end_doneq", 32'(doneQ.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
